// File: rtl/img_mnist_pkg.sv
// Shared constants and FSM state encoding for the MNIST input path.
// Used by the frame packer and any block that must agree on the 28x28 geometry.
package img_mnist_pkg;

    localparam int MNIST_X      = 28;
    localparam int MNIST_Y      = 28;
    localparam int MNIST_PIXELS = MNIST_X * MNIST_Y;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

endpackage

// File: rtl/img_mnist_frame_packer_if.sv
// Pixel stream in / packed frame out bundle of the MNIST frame packer.
// master = upstream producer side, slave = the packer itself.
interface img_mnist_frame_packer_if #(
    parameter int USER_BITS  = 1,
    parameter int DATA_WIDTH = 8,
    parameter int IMG_X      = 28,
    parameter int IMG_Y      = 28
);

    logic [USER_BITS-1:0]   s_user;
    logic                   s_frame_start;
    logic                   s_line_end;
    logic [DATA_WIDTH-1:0]  s_data;
    logic                   s_valid;

    logic [USER_BITS-1:0]   m_user;
    logic [IMG_X*IMG_Y-1:0] m_data;
    logic                   m_valid;

    modport master (
        output s_user, s_frame_start, s_line_end, s_data, s_valid,
        input  m_user, m_data, m_valid
    );

    modport slave (
        input  s_user, s_frame_start, s_line_end, s_data, s_valid,
        output m_user, m_data, m_valid
    );

endinterface

// File: rtl/img_mnist_binarizer.sv
// Combinational grayscale-to-bit threshold: bit = (data >= threshold), unsigned.
// Kept standalone so the classifier path can reuse the same compare.
module img_mnist_binarizer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [DATA_WIDTH-1:0] threshold,
    output logic                  pix_bit
);

    assign pix_bit = (data >= threshold);

endmodule

// File: rtl/img_mnist_frame_packer.sv
// Binarizes a 28x28 raster pixel stream and packs one frame into a single word.
// Optional macro IMG_MNIST_FRAME_PACKER_ERR_COUNT_EN adds an 8-bit saturating err_count port.
module img_mnist_frame_packer
    import img_mnist_pkg::*;
#(
    parameter int USER_WIDTH = 0,
    parameter int USER_BITS  = (USER_WIDTH > 0 ? USER_WIDTH : 1),
    parameter int DATA_WIDTH = 8,
    parameter int IMG_X      = MNIST_X,
    parameter int IMG_Y      = MNIST_Y
) (
    input  logic                  reset,
    input  logic                  clk,
    input  logic                  cke,
    input  logic [DATA_WIDTH-1:0] param_th,
    img_mnist_frame_packer_if.slave bus
`ifdef IMG_MNIST_FRAME_PACKER_ERR_COUNT_EN
    ,
    output logic [7:0]            err_count
`endif
);

    localparam int PIXELS = IMG_X * IMG_Y;
    localparam int XW     = $clog2(IMG_X);
    localparam int YW     = $clog2(IMG_Y);
    localparam int IW     = $clog2(PIXELS);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_X - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_Y - 1);

    state_t                state_q, state_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [PIXELS-1:0]     asm_q, asm_d;
    logic [USER_BITS-1:0]  user_q;

    logic                  m_valid_q;
    logic [PIXELS-1:0]     m_data_q;
    logic [USER_BITS-1:0]  m_user_q;

    logic                  accept;
    logic                  pix_bit;
    logic                  start;
    logic                  wr_en;
    logic [IW-1:0]         wr_idx;
    logic                  emit;
    logic                  err_evt;

    img_mnist_binarizer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_binarizer (
        .data      (bus.s_data),
        .threshold (param_th),
        .pix_bit   (pix_bit)
    );

    assign accept = bus.s_valid && cke;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
        end else if (cke) begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // Frame start wins over everything else, including the would-be last pixel.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // a signal unassigned, which would infer a latch; combinational blocks use =.
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        start   = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = '0;
        emit    = 1'b0;
        err_evt = 1'b0;

        if (accept) begin
            if (bus.s_frame_start) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_idx  = '0;
                x_d     = XW'(1);
                y_d     = '0;
                state_d = ST_FILL;
                err_evt = (state_q == ST_FILL);
            end else if (state_q == ST_FILL) begin
                wr_en  = 1'b1;
                wr_idx = IW'(y_q) * IW'(IMG_X) + IW'(x_q);
                if (x_q != X_LAST) begin
                    if (bus.s_line_end) begin
                        state_d = ST_IDLE;
                        err_evt = 1'b1;
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end else if (!bus.s_line_end) begin
                    state_d = ST_IDLE;
                    err_evt = 1'b1;
                end else if (y_q != Y_LAST) begin
                    x_d = '0;
                    y_d = y_q + YW'(1);
                end else begin
                    emit    = 1'b1;
                    state_d = ST_IDLE;
                end
                if (state_d == ST_IDLE) begin
                    x_d = '0;
                    y_d = '0;
                end
            end
        end
    end

    always_comb begin
        asm_d = asm_q;
        if (wr_en) begin
            asm_d[wr_idx] = pix_bit;
        end
    end

    // NOTE: the assembly register has no reset; every bit is rewritten before a frame
    // can be emitted, so its power-up contents are never observable.
    always_ff @(posedge clk) begin
        if (cke) begin
            asm_q <= asm_d;
        end
    end

    // The emitted word takes asm_d so the final pixel lands in the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            user_q    <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_user_q  <= '0;
        end else if (cke) begin
            if (start) begin
                user_q <= bus.s_user;
            end
            m_valid_q <= emit;
            if (emit) begin
                m_data_q <= asm_d;
                m_user_q <= user_q;
            end
        end
    end

    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_user  = m_user_q;

`ifdef IMG_MNIST_FRAME_PACKER_ERR_COUNT_EN
    logic [7:0] err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= '0;
        end else if (cke && err_evt && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_count = err_q;
`else
    logic unused_err_evt;
    assign unused_err_evt = err_evt;
`endif

endmodule

// File: tb/tb_img_mnist_frame_packer.sv
// Directed bench for img_mnist_frame_packer: frame-level model plus literal spot checks.
// Also checks err_count when IMG_MNIST_FRAME_PACKER_ERR_COUNT_EN is defined.
module tb_img_mnist_frame_packer;
    import img_mnist_pkg::*;

    localparam int UW = 8;
    localparam int UB = 8;
    localparam int DW = 8;
    localparam int NX = MNIST_X;
    localparam int NY = MNIST_Y;
    localparam int NP = MNIST_PIXELS;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          cke   = 1'b1;
    logic [DW-1:0] th    = 8'd128;

    img_mnist_frame_packer_if #(
        .USER_BITS (UB), .DATA_WIDTH (DW), .IMG_X (NX), .IMG_Y (NY)
    ) bus ();

`ifdef IMG_MNIST_FRAME_PACKER_ERR_COUNT_EN
    logic [7:0] err_count;
`endif

    img_mnist_frame_packer #(
        .USER_WIDTH (UW), .USER_BITS (UB), .DATA_WIDTH (DW), .IMG_X (NX), .IMG_Y (NY)
    ) dut (
        .reset    (reset),
        .clk      (clk),
        .cke      (cke),
        .param_th (th),
        .bus      (bus)
`ifdef IMG_MNIST_FRAME_PACKER_ERR_COUNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]    pix [NY][NX];
    bit            gap_mode      = 1'b0;
    int            stall_at      = -1;
    int            pix_count     = 0;
    bit            drv_last_good = 1'b0;
    logic [NP-1:0] pend_data     = '0;
    logic [UB-1:0] pend_user     = '0;

    logic          exp_valid = 1'b0;
    logic [NP-1:0] exp_data  = '0;
    logic [UB-1:0] exp_user  = '0;

    task automatic check(input string name, input logic [NP-1:0] act, input logic [NP-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame word straight from the definition: bit y*NX+x is (pixel >= threshold).
    function automatic logic [NP-1:0] expected_bits();
        logic [NP-1:0] b;
        for (int y = 0; y < NY; y++)
            for (int x = 0; x < NX; x++)
                b[y*NX + x] = (pix[y][x] >= th);
        return b;
    endfunction

    // Model: a completed frame shows up on the outputs after the cke edge that
    // accepts its last pixel; valid drops at the following cke edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_valid <= 1'b0;
            exp_data  <= '0;
            exp_user  <= '0;
        end else if (cke) begin
            if (bus.s_valid && drv_last_good) begin
                exp_valid <= 1'b1;
                exp_data  <= pend_data;
                exp_user  <= pend_user;
            end else begin
                exp_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("m_valid", {{(NP-1){1'b0}}, bus.m_valid}, {{(NP-1){1'b0}}, exp_valid});
        check("m_data", bus.m_data, exp_data);
        check("m_user", NP'(bus.m_user), NP'(exp_user));
    end

    task automatic drive(input logic [7:0] d, input logic fs, input logic le,
                         input logic [UB-1:0] u, input bit last_good);
        if (gap_mode) repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.s_data        = d;
        bus.s_frame_start = fs;
        bus.s_line_end    = le;
        bus.s_user        = fs ? u : ~u;
        bus.s_valid       = 1'b1;
        drv_last_good     = last_good;
        if (last_good) begin
            pend_data = expected_bits();
            pend_user = u;
        end
        if (pix_count == stall_at) begin
            cke = 1'b0;
            repeat (3) @(negedge clk);
            cke = 1'b1;
        end
        pix_count++;
        @(negedge clk);
        bus.s_valid       = 1'b0;
        bus.s_frame_start = 1'b0;
        bus.s_line_end    = 1'b0;
        drv_last_good     = 1'b0;
    endtask

    task automatic send_pix(input int idx, input logic fs, input logic [UB-1:0] u, input bit last_good);
        int x;
        int y;
        x = idx % NX;
        y = idx / NX;
        drive(pix[y][x], fs, (x == NX-1), u, last_good);
    endtask

    task automatic send_frame(input logic [UB-1:0] u);
        for (int i = 0; i < NP; i++) send_pix(i, (i == 0), u, (i == NP-1));
    endtask

    task automatic send_partial(input logic [UB-1:0] u, input int n);
        for (int i = 0; i < n; i++) send_pix(i, (i == 0), u, 1'b0);
    endtask

    task automatic fill_checker();
        for (int y = 0; y < NY; y++)
            for (int x = 0; x < NX; x++)
                pix[y][x] = ((x + y) % 2 == 0) ? 8'd200 : 8'd50;
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int y = 0; y < NY; y++)
            for (int x = 0; x < NX; x++)
                pix[y][x] = v;
    endtask

    task automatic fill_random();
        for (int y = 0; y < NY; y++)
            for (int x = 0; x < NX; x++)
                pix[y][x] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.s_data        = '0;
        bus.s_frame_start = 1'b0;
        bus.s_line_end    = 1'b0;
        bus.s_user        = '0;
        bus.s_valid       = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_m_valid", NP'(bus.m_valid), '0);
        check("rst_m_data", bus.m_data, '0);
        check("rst_m_user", NP'(bus.m_user), '0);
`ifdef IMG_MNIST_FRAME_PACKER_ERR_COUNT_EN
        check("rst_err_count", NP'(err_count), NP'(0));
`endif
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Clean checkerboard frame
        th = 8'd128;
        fill_checker();
        send_frame(8'hA5);
        check("latency_pulse", NP'(bus.m_valid), NP'(1));
        check("chk_bit_x0_y0", NP'(bus.m_data[0]), NP'(1));
        check("chk_bit_x1_y0", NP'(bus.m_data[1]), NP'(0));
        check("chk_bit_x0_y1", NP'(bus.m_data[NX]), NP'(0));
        check("chk_bit_x1_y1", NP'(bus.m_data[NX+1]), NP'(1));
        check("chk_bit_x27_y27", NP'(bus.m_data[NP-1]), NP'(1));
        check("chk_user", NP'(bus.m_user), NP'(8'hA5));
        @(negedge clk);
        check("pulse_one_cycle", NP'(bus.m_valid), NP'(0));

        // Same frame with random valid gaps and a 3-cycle cke stall mid-frame
        gap_mode = 1'b1;
        stall_at = pix_count + 400;
        send_frame(8'h3C);
        gap_mode = 1'b0;
        stall_at = -1;
        check("gapped_pulse", NP'(bus.m_valid), NP'(1));
        check("gapped_bit_x27_y27", NP'(bus.m_data[NP-1]), NP'(1));
        cke = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("valid_holds_cke_low", NP'(bus.m_valid), NP'(1));
        end
        cke = 1'b1;
        @(negedge clk);
        check("valid_drops_after_cke", NP'(bus.m_valid), NP'(0));

        // Early line end on line 5 at x=20, stray pixels, then a clean frame
        send_partial(8'h51, 5*NX + 20);
        drive(pix[5][20], 1'b0, 1'b1, 8'h51, 1'b0);
        repeat (5) drive(8'hFF, 1'b0, 1'b1, 8'h5A, 1'b0);
`ifdef IMG_MNIST_FRAME_PACKER_ERR_COUNT_EN
        check("err_early_line_end", NP'(err_count), NP'(1));
`endif
        fill_random();
        send_frame(8'h11);
        check("after_err_user", NP'(bus.m_user), NP'(8'h11));

        // Missing line end at x=27 on line 3
        send_partial(8'h52, 3*NX + 27);
        drive(pix[3][27], 1'b0, 1'b0, 8'h52, 1'b0);
`ifdef IMG_MNIST_FRAME_PACKER_ERR_COUNT_EN
        check("err_missing_line_end", NP'(err_count), NP'(2));
`endif

        // Frame start injected at line 10 aborts the frame; the next one emits
        fill_checker();
        send_partial(8'h61, 10*NX + 5);
        fill_random();
        send_frame(8'h22);
        check("abort_second_user", NP'(bus.m_user), NP'(8'h22));
`ifdef IMG_MNIST_FRAME_PACKER_ERR_COUNT_EN
        check("err_abort", NP'(err_count), NP'(3));
`endif

        // Frame start on the would-be last pixel restarts instead of emitting
        send_partial(8'h71, NP-1);
        drive(pix[0][0], 1'b1, 1'b1, 8'h33, 1'b0);
        for (int i = 1; i < NP; i++) send_pix(i, 1'b0, 8'h33, (i == NP-1));
        check("restart_on_last_user", NP'(bus.m_user), NP'(8'h33));
`ifdef IMG_MNIST_FRAME_PACKER_ERR_COUNT_EN
        check("err_restart_on_last", NP'(err_count), NP'(4));
`endif

        // Reset during line 14, stray pixels, then a clean frame
        send_partial(8'h81, 14*NX + 10);
        reset = 1'b1;
        #1;
        check("midreset_m_valid", NP'(bus.m_valid), NP'(0));
        check("midreset_m_data", bus.m_data, '0);
        check("midreset_m_user", NP'(bus.m_user), NP'(0));
`ifdef IMG_MNIST_FRAME_PACKER_ERR_COUNT_EN
        check("midreset_err_count", NP'(err_count), NP'(0));
`endif
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 1; i < NX; i++) send_pix(i, 1'b0, 8'h82, 1'b0);
        fill_random();
        send_frame(8'h44);
        check("post_reset_user", NP'(bus.m_user), NP'(8'h44));

        // Threshold boundary
        fill_const(8'd100);
        th = 8'd100;
        send_frame(8'h90);
        check("th_equal_all_ones", bus.m_data, {NP{1'b1}});
        th = 8'd101;
        send_frame(8'h91);
        check("th_above_all_zeros", bus.m_data, {NP{1'b0}});

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
